scr1_tb_host_ahb: RTL
=====================

// Module: scr1_tb_host_ahb
// PURPOSE
//  AHB-Lite point-to-point responder for the testbench host device on the dmem port.
//  Gives test software a memory-mapped exit register (pass/fail code), a console byte FIFO and IRQ controls.
//  These replace PC-snooping exit detection and hard-tied soft_irq/ext_irq in the AHB top bench.
//  Sits beside the AHB memory model behind the dmem address decoder.
// PARAMETERS
//  FIFO_DEPTH   8   console FIFO entries (power of 2, >=2)
//  WAIT_STATES  0   fixed extra hready-low cycles per data phase (0..15)
// PORTS
//  clk        in   1   core clock
//  rst        in   1   asynchronous reset, active high
//  hsel       in   1   device selected by decoder
//  htrans     in   2   AHB transfer type
//  hsize      in   3   AHB transfer size
//  haddr      in   32  AHB address; only haddr[3:0] decoded
//  hwrite     in   1   1=write
//  hwdata     in   32  write data, valid in data phase
//  hready     out  1   transfer done / slave ready (point-to-point, no hready_in)
//  hrdata     out  32  read data
//  hresp      out  1   0=OKAY 1=ERROR
//  cons_valid out  1   console byte available
//  cons_data  out  8   console byte (FIFO head)
//  cons_ready in   1   bench consumes byte when valid&ready
//  test_done  out  1   level, set by first EXIT write
//  test_code  out  32  code from first EXIT write (0 = pass)
//  soft_irq   out  1   software IRQ level
//  ext_irq    out  1   external IRQ level
// BEHAVIOUR
//  Reset values: hready=1, hresp=0, hrdata=0, cons_valid=0, test_done=0, test_code=0.
//  Reset values (cont.): soft_irq=0, ext_irq=0, FIFO empty, delay counter=0.
//  Reset mid-transfer aborts it; no write side effects after rst asserts.
//  Address phase accepted when hsel & htrans[1] & hready; regs addr[3:0], size, write, and error flag.
//  IDLE/BUSY or ~hsel: no data phase; next cycle hready=1, hresp=0.
//  Data-phase FSM states: IDLE, WAIT, ERR1, ERR2.
//   IDLE: hready=1, hresp=0.
//   Accepted phase with ERROR:
//    ERR1: hready=0, hresp=1.
//    ERR2: hready=1, hresp=1.
//    Then IDLE, or the next phase accepted in ERR2.
//   Accepted phase otherwise: WAIT for WAIT_STATES cycles, hready=0.
//    CONSOLE write with FIFO full: hready stays low until a slot frees.
//    Completion cycle: hready=1; write side effect occurs; hrdata valid for reads.
//   With WAIT_STATES=0 and no stall, the data phase completes in the cycle after the address phase.
//  Registers (offset; non-console access must be word, hsize=2):
//   0x0 EXIT   W: first write sets test_done=1 and test_code=hwdata; later writes ignored.
//              R: {test_done, test_code[30:0]}.
//   0x4 CONS   W: any size; pushes hwdata[8*addr[1:0]+:8].
//              R: {24'b0, count} (count width $clog2(FIFO_DEPTH)+1).
//   0x8 IRQC   RW: bit0=soft_irq, bit1=ext_irq; other bits read 0.
//   0xC DELAY  W: loads 32-bit down counter. R: current count.
//              Counter decrements each cycle while nonzero.
//              On the 1->0 transition it sets ext_irq=1.
//              Load value 0 stops the counter, no IRQ.
//  ERROR response: non-word access to 0x0, 0x8 or 0xC.
//  Unmapped offsets: none (4 regs fill the window).
//  Simultaneous events:
//   - IRQC write and counter expiry in the same cycle: the IRQC write value wins for ext_irq.
//   - DELAY write during countdown: reload; no IRQ from the old count.
//   - FIFO full with push and pop in the same cycle: push accepted, count unchanged, no stall that cycle.
//   - FIFO empty: cons_valid=0; cons_data holds the last head.
//  FIFO pointers wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH.
// TESTING
//  1. Write EXIT 0x0 (word), then write EXIT 0x5:
//     test_done=1, test_code=0 after the first write; stays 0 after the second; read 0x0 = 0x80000000.
//  2. FIFO_DEPTH=8, cons_ready=0, 9 byte writes to 0x4 ('A'..'I'):
//     the 9th data phase holds hready=0.
//     Raise cons_ready for 1 cycle: 'A' pops, 9th completes, count=8.
//  3. Halfword write to 0x8:
//     cycle1 hready=0 hresp=1; cycle2 hready=1 hresp=1; soft_irq unchanged.
//  4. Write DELAY=3:
//     ext_irq rises exactly 3 cycles after the write completes.
//     Write IRQC=0: ext_irq=0.
//     Repeat, writing IRQC=0 in the expiry cycle: ext_irq stays 0.
//  5. WAIT_STATES=2, back-to-back reads of 0x4 and 0x8: each data phase shows 2 hready-low cycles and correct hrdata.
//  6. Assert rst during a stalled CONS write:
//     hready=1, FIFO empty, all IRQ outputs 0 asynchronously.

Source files
------------

// File: rtl/scr1_tb_host_ahb.sv
// AHB-Lite responder for the testbench host: an exit register, a console byte FIFO,
// IRQ control bits and a delay timer that raises ext_irq when it expires.
module scr1_tb_host_ahb #(
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic        hresp,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        test_done,
  output logic [31:0] test_code,
  output logic        soft_irq,
  output logic        ext_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                   state, state_nx;
  logic [3:0]               dp_addr;
  logic                     dp_write;
  logic [3:0]               wcnt;
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]            wptr, rptr, head_idx;
  logic [CW-1:0]            count;
  logic [31:0]              dly;
  logic                     accept, a_err, dp_cons, fifo_full, pop, stall, complete;
  logic                     wr_ev, push, exit_wr, irqc_wr, dly_wr;
  logic [7:0]               wbyte;
  logic                     unused;

  assign unused = ^{haddr[31:4], htrans[0]};

  assign accept    = hsel & htrans[1] & hready;
  // only the console register tolerates sub-word accesses
  assign a_err     = (hsize != 3'd2) && (haddr[3:2] != 2'd1);
  assign dp_cons   = (dp_addr[3:2] == 2'd1);
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign pop       = cons_valid & cons_ready;
  // a pop in the same cycle frees the slot, so a full FIFO does not stall then
  assign stall     = dp_write & dp_cons & fifo_full & ~pop;
  assign complete  = (state == ST_WAIT) && (wcnt == 4'd0) && !stall;

  assign hready = (state == ST_WAIT) ? complete : (state != ST_ERR1);
  assign hresp  = (state == ST_ERR1) || (state == ST_ERR2);

  always_comb begin
    state_nx = state;
    if (hready) begin
      if (accept) state_nx = a_err ? ST_ERR1 : ST_WAIT;
      else        state_nx = ST_IDLE;
    end else if (state == ST_ERR1) begin
      state_nx = ST_ERR2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dp_addr  <= 4'd0;
      dp_write <= 1'b0;
      wcnt     <= 4'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        dp_addr  <= haddr[3:0];
        dp_write <= hwrite;
      end
      if (accept && !a_err)                         wcnt <= 4'(WAIT_STATES);
      else if (state == ST_WAIT && wcnt != 4'd0)    wcnt <= wcnt - 4'd1;
    end
  end

  assign wr_ev   = complete & dp_write;
  assign push    = wr_ev & dp_cons;
  assign exit_wr = wr_ev && (dp_addr[3:2] == 2'd0);
  assign irqc_wr = wr_ev && (dp_addr[3:2] == 2'd2);
  assign dly_wr  = wr_ev && (dp_addr[3:2] == 2'd3);
  assign wbyte   = hwdata[{dp_addr[1:0], 3'b000} +: 8];

  // console FIFO; when empty the output keeps showing the last byte popped
  assign cons_valid = (count != '0);
  assign head_idx   = cons_valid ? rptr : AW'(rptr - 1'b1);
  assign cons_data  = mem[head_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wbyte;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_done <= 1'b0;
      test_code <= 32'd0;
      soft_irq  <= 1'b0;
      ext_irq   <= 1'b0;
      dly       <= 32'd0;
    end else begin
      if (exit_wr && !test_done) begin
        test_done <= 1'b1;
        test_code <= hwdata;
      end
      if (dly_wr)              dly <= hwdata;
      else if (dly != 32'd0)   dly <= dly - 32'd1;
      // an IRQC write overrides a same-cycle expiry; a reload cancels it
      if (irqc_wr) begin
        soft_irq <= hwdata[0];
        ext_irq  <= hwdata[1];
      end else if (!dly_wr && dly == 32'd1) begin
        ext_irq  <= 1'b1;
      end
    end
  end

  always_comb begin
    hrdata = 32'd0;
    if (complete && !dp_write) begin
      case (dp_addr[3:2])
        2'd0:    hrdata = {test_done, test_code[30:0]};
        2'd1:    hrdata = 32'(count);
        2'd2:    hrdata = {30'd0, ext_irq, soft_irq};
        default: hrdata = dly;
      endcase
    end
  end
endmodule
